alarm_clock_multi: RTL

Parametrised successor to the single-alarm core: a 24-hour time-of-day counter with `NUM_ALARMS` independent alarm channels, auto-timeout, and a snooze state machine. Sits behind the `tt_um_*` top wrapper. The wrapper maps `ui_in`/`uio_in` to the set/control strobes and `uo_out` to time digits and buzzer. All outputs are registered.

---
 rtl/alarm_clock_multi_if.sv | 33 +++
 rtl/alarm_clock_multi.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_clock_multi_if.sv
// alarm_clock_multi_if: control strobes and status outputs of the alarm clock core.
// The master side drives the set/control strobes; the slave side (the core) returns time and ring status.
interface alarm_clock_multi_if #(
    parameter int SW = 2
);
    logic          ena;
    logic          set_time;
    logic [4:0]    set_hh;
    logic [5:0]    set_mm;
    logic          alarm_wr;
    logic [SW-1:0] alarm_sel;
    logic          alarm_on;
    logic          snooze;
    logic          stop;

    logic [4:0]    hh;
    logic [5:0]    mm;
    logic [5:0]    ss;
    logic          ringing;
    logic          snoozed;
    logic [SW-1:0] ring_id;
    logic          buzzer;

    modport master (
        output ena, set_time, set_hh, set_mm, alarm_wr, alarm_sel, alarm_on, snooze, stop,
        input  hh, mm, ss, ringing, snoozed, ring_id, buzzer
    );

    modport slave (
        input  ena, set_time, set_hh, set_mm, alarm_wr, alarm_sel, alarm_on, snooze, stop,
        output hh, mm, ss, ringing, snoozed, ring_id, buzzer
    );
endinterface

// File: rtl/alarm_clock_multi.sv
// alarm_clock_multi: 24-hour time-of-day counter with NUM_ALARMS alarm channels,
// automatic ring timeout and an optional snooze state machine.
// Optional feature macro: ALARM_SNOOZE_EN builds the SNOOZED state, its countdown
// and the snooze input; without it snooze is ignored and snoozed is tied low.
module alarm_clock_multi #(
    parameter int TICK_DIV   = 50_000_000,
    parameter int NUM_ALARMS = 4,
    parameter int SNOOZE_S   = 300,
    parameter int RING_MAX_S = 60
) (
    input  logic clk,
    input  logic rst_n,
    alarm_clock_multi_if.slave bus
);
    localparam int SW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;
    localparam int PW = $clog2(TICK_DIV);
    localparam int RW = (RING_MAX_S > 1) ? $clog2(RING_MAX_S) : 1;
    localparam logic [PW-1:0] PRESC_MAX  = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PRESC_HALF = PW'(TICK_DIV / 2);
    localparam logic [RW-1:0] RING_LAST  = RW'(RING_MAX_S - 1);

`ifdef ALARM_SNOOZE_EN
    localparam int NW = (SNOOZE_S > 0) ? $clog2(SNOOZE_S + 1) : 1;
    localparam logic [NW-1:0] SNOOZE_LOAD = NW'(SNOOZE_S);
    typedef enum logic [1:0] {S_IDLE, S_RING, S_SNZ} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_RING} state_t;
`endif

    // ---------------- time base ----------------
    logic [PW-1:0] presc_q, presc_d;
    logic [4:0]    hh_q, hh_d;
    logic [5:0]    mm_q, mm_d;
    logic [5:0]    ss_q, ss_d;

    logic in_range, set_ok, wr_ok, tick;

    // Out-of-range time values make the whole strobe a no-op.
    assign in_range = (bus.set_hh <= 5'd23) && (bus.set_mm <= 6'd59);
    assign set_ok   = bus.set_time && in_range;
    assign wr_ok    = bus.alarm_wr && in_range && (int'(bus.alarm_sel) < NUM_ALARMS);
    // A valid set_time wins over a tick landing in the same cycle.
    assign tick     = bus.ena && (presc_q == PRESC_MAX) && !set_ok;

    // Next time: load on set_time, otherwise prescale and advance hh:mm:ss on tick.
    always_comb begin
        presc_d = presc_q;
        hh_d    = hh_q;
        mm_d    = mm_q;
        ss_d    = ss_q;
        if (set_ok) begin
            presc_d = '0;
            hh_d    = bus.set_hh;
            mm_d    = bus.set_mm;
            ss_d    = '0;
        end else if (bus.ena) begin
            if (presc_q == PRESC_MAX) begin
                presc_d = '0;
                if (ss_q == 6'd59) begin
                    ss_d = '0;
                    if (mm_q == 6'd59) begin
                        mm_d = '0;
                        hh_d = (hh_q == 5'd23) ? 5'd0 : hh_q + 5'd1;
                    end else begin
                        mm_d = mm_q + 6'd1;
                    end
                end else begin
                    ss_d = ss_q + 6'd1;
                end
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
    end

    // Time and prescaler registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            hh_q    <= '0;
            mm_q    <= '0;
            ss_q    <= '0;
        end else begin
            presc_q <= presc_d;
            hh_q    <= hh_d;
            mm_q    <= mm_d;
            ss_q    <= ss_d;
        end
    end

    // ---------------- alarm channels ----------------
    logic [4:0]            al_hh_q [NUM_ALARMS];
    logic [5:0]            al_mm_q [NUM_ALARMS];
    logic [NUM_ALARMS-1:0] al_en_q;

    // Channel store; writes are accepted regardless of ena and never touch the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                al_hh_q[i] <= '0;
                al_mm_q[i] <= '0;
            end
            al_en_q <= '0;
        end else begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                if (wr_ok && (bus.alarm_sel == SW'(i))) begin
                    al_hh_q[i] <= bus.set_hh;
                    al_mm_q[i] <= bus.set_mm;
                    al_en_q[i] <= bus.alarm_on;
                end
            end
        end
    end

    logic          match;
    logic [SW-1:0] match_id;

    // Match on the time a tick produces; scan downwards so the lowest channel wins.
    always_comb begin
        match    = 1'b0;
        match_id = '0;
        if (tick && (ss_d == 6'd0)) begin
            for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
                if (al_en_q[i] && (al_hh_q[i] == hh_d) && (al_mm_q[i] == mm_d)) begin
                    match    = 1'b1;
                    match_id = SW'(i);
                end
            end
        end
    end

    // ---------------- ring / snooze FSM ----------------
    state_t        state_q, state_d;
    logic [SW-1:0] id_q, id_d;
    logic [RW-1:0] ring_cnt_q, ring_cnt_d;
    logic          ringing_q, snoozed_q, buzzer_q;
`ifdef ALARM_SNOOZE_EN
    logic [NW-1:0] snz_cnt_q, snz_cnt_d;
`else
    logic          unused_snooze;
    assign unused_snooze = bus.snooze;
`endif

    // Next state: stop beats everything, then snooze, then timeout / countdown expiry.
    always_comb begin
        state_d    = state_q;
        id_d       = id_q;
        ring_cnt_d = ring_cnt_q;
`ifdef ALARM_SNOOZE_EN
        snz_cnt_d  = snz_cnt_q;
`endif
        if (bus.ena) begin
            case (state_q)
                S_IDLE: begin
                    if (match && !bus.stop) begin
                        state_d    = S_RING;
                        id_d       = match_id;
                        ring_cnt_d = '0;
                    end
                end
                S_RING: begin
                    if (bus.stop) begin
                        state_d = S_IDLE;
`ifdef ALARM_SNOOZE_EN
                    end else if (bus.snooze) begin
                        state_d   = S_SNZ;
                        snz_cnt_d = SNOOZE_LOAD;
`endif
                    end else if (tick) begin
                        if (ring_cnt_q == RING_LAST) state_d = S_IDLE;
                        else                         ring_cnt_d = ring_cnt_q + RW'(1);
                    end
                end
`ifdef ALARM_SNOOZE_EN
                S_SNZ: begin
                    if (bus.stop) begin
                        state_d = S_IDLE;
                    end else if (match) begin
                        state_d    = S_RING;
                        id_d       = match_id;
                        ring_cnt_d = '0;
                    end else if (tick) begin
                        if (snz_cnt_q <= NW'(1)) begin
                            state_d    = S_RING;
                            ring_cnt_d = '0;
                            snz_cnt_d  = '0;
                        end else begin
                            snz_cnt_d = snz_cnt_q - NW'(1);
                        end
                    end
                end
`endif
                default: state_d = S_IDLE;
            endcase
        end
    end

    // FSM state plus registered status outputs derived from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            id_q       <= '0;
            ring_cnt_q <= '0;
            ringing_q  <= 1'b0;
            snoozed_q  <= 1'b0;
            buzzer_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            id_q       <= id_d;
            ring_cnt_q <= ring_cnt_d;
            ringing_q  <= (state_d == S_RING);
`ifdef ALARM_SNOOZE_EN
            snoozed_q  <= (state_d == S_SNZ);
`else
            snoozed_q  <= 1'b0;
`endif
            buzzer_q   <= (state_d == S_RING) && (presc_d < PRESC_HALF);
        end
    end

`ifdef ALARM_SNOOZE_EN
    // Snooze countdown register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) snz_cnt_q <= '0;
        else        snz_cnt_q <= snz_cnt_d;
    end
`endif

    assign bus.hh      = hh_q;
    assign bus.mm      = mm_q;
    assign bus.ss      = ss_q;
    assign bus.ringing = ringing_q;
    assign bus.snoozed = snoozed_q;
    assign bus.ring_id = id_q;
    assign bus.buzzer  = buzzer_q;

endmodule
